circle_drawer: RTL and testbench



---
 rtl/circle_pkg.sv | 26 ++
 rtl/circle_octant_point.sv | 38 +++
 rtl/circle_drawer.sv | 132 +++++++++++++
 tb/tb_circle_drawer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// Shared types and screen limits for the circle drawer and related shape blocks.
// Pure declarations; no logic, no latency.
// Used by every block that emits framebuffer points.
package circle_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Signed 10-bit coordinate: wide enough that centre +/- radius never wraps.
    typedef logic signed [9:0] coord_t;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        OCT1,
        OCT2,
        OCT3,
        OCT4,
        OCT5,
        OCT6,
        OCT7,
        OCT8,
        DONE
    } state_t;

endpackage

// File: rtl/circle_octant_point.sv
// Maps an octant index and (ox, oy) offset to a screen point, flagging on-screen points.
// Purely combinational, zero latency.
// No flow control; the caller decides what to do with off-screen points.
module circle_octant_point
    import circle_pkg::*;
(
    input  logic [2:0] oct_i,
    input  coord_t     cx_i,
    input  coord_t     cy_i,
    input  coord_t     ox_i,
    input  coord_t     oy_i,
    output coord_t     px_o,
    output coord_t     py_o,
    output logic       on_screen_o
);

    localparam coord_t MAX_X = coord_t'(SCREEN_W);
    localparam coord_t MAX_Y = coord_t'(SCREEN_H);

    // Select the mirrored point for this octant, then test it against the visible area.
    always_comb begin
        px_o = cx_i;
        py_o = cy_i;
        case (oct_i)
            3'd0: begin px_o = cx_i + ox_i; py_o = cy_i + oy_i; end
            3'd1: begin px_o = cx_i + oy_i; py_o = cy_i + ox_i; end
            3'd2: begin px_o = cx_i - ox_i; py_o = cy_i + oy_i; end
            3'd3: begin px_o = cx_i - oy_i; py_o = cy_i + ox_i; end
            3'd4: begin px_o = cx_i - ox_i; py_o = cy_i - oy_i; end
            3'd5: begin px_o = cx_i - oy_i; py_o = cy_i - ox_i; end
            3'd6: begin px_o = cx_i + ox_i; py_o = cy_i - oy_i; end
            default: begin px_o = cx_i + oy_i; py_o = cy_i - ox_i; end
        endcase
        on_screen_o = (px_o >= 10'sd0) && (px_o < MAX_X) &&
                      (py_o >= 10'sd0) && (py_o < MAX_Y);
    end

endmodule

// File: rtl/circle_drawer.sv
// Midpoint circle outline into the 160x120 framebuffer, one octant point per cycle.
// First pixel two cycles after start is sampled; 8 cycles per iteration; done one cycle after last pixel.
// No backpressure from the adapter; start/done level handshake sequences it with other blocks.
module circle_drawer
    import circle_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    state_t     state_q;
    coord_t     cx_q, cy_q, ox_q, oy_q, crit_q;
    logic [2:0] colour_q;
    logic       done_q, plot_q;
    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] vcol_q;

    coord_t     ox_d, oy_d, crit_d;
    logic       more_d;
    logic [2:0] oct_idx;
    logic       in_oct;
    coord_t     px, py;
    logic       on_screen;
    logic       unused_hi_bits;

    assign in_oct  = (state_q inside {[OCT1:OCT8]});
    assign oct_idx = 3'(4'(state_q) - 4'(OCT1));

    circle_octant_point u_point (
        .oct_i       (oct_idx),
        .cx_i        (cx_q),
        .cy_i        (cy_q),
        .ox_i        (ox_q),
        .oy_i        (oy_q),
        .px_o        (px),
        .py_o        (py),
        .on_screen_o (on_screen)
    );

    // High coordinate bits are zero whenever a point is plotted.
    assign unused_hi_bits = ^{px[9:8], py[9:7]};

    // Midpoint step applied at the end of each 8-point iteration.
    always_comb begin
        ox_d = ox_q + 10'sd1;
        oy_d = oy_q;
        crit_d = crit_q + (ox_d <<< 1) + 10'sd1;
        if (crit_q > 10'sd0) begin
            oy_d   = oy_q - 10'sd1;
            crit_d = crit_q + ((ox_d - oy_d) <<< 1) + 10'sd1;
        end
        more_d = (oy_d >= ox_d);
    end

    // Control FSM with registered pixel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            crit_q   <= '0;
            colour_q <= '0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            vcol_q   <= '0;
        end else begin
            plot_q <= 1'b0;
            if (in_oct) begin
                vcol_q <= colour_q;
                if (on_screen) begin
                    plot_q <= 1'b1;
                    x_q    <= px[7:0];
                    y_q    <= py[6:0];
                end
            end
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) state_q <= INIT;
                end
                INIT: begin
                    cx_q     <= coord_t'({2'b00, centre_x});
                    cy_q     <= coord_t'({3'b000, centre_y});
                    ox_q     <= '0;
                    oy_q     <= coord_t'({2'b00, radius});
                    crit_q   <= 10'sd1 - coord_t'({2'b00, radius});
                    colour_q <= colour;
                    state_q  <= OCT1;
                end
                OCT8: begin
                    ox_q    <= ox_d;
                    oy_q    <= oy_d;
                    crit_q  <= crit_d;
                    state_q <= more_d ? OCT1 : DONE;
                end
                DONE: begin
                    // First DONE cycle always raises done, so a dropped start still sees a pulse.
                    if (!done_q) begin
                        done_q <= 1'b1;
                        if (!start) state_q <= IDLE;
                    end else if (!start) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= state_t'(4'(state_q) + 4'd1);
            endcase
        end
    end

    assign done       = done_q;
    assign vga_plot   = plot_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = vcol_q;

endmodule

// File: tb/tb_circle_drawer.sv
// Directed table-driven bench for circle_drawer with a point-list reference model.
module tb_circle_drawer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] colour;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    circle_drawer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .colour     (colour),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .radius     (radius),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference point list: one entry per octant cycle.
    int m_x[$];
    int m_y[$];
    bit m_on[$];

    function automatic void build_model(input int cx, input int cy, input int r);
        int x, y, d;
        int px[8];
        int py[8];
        m_x.delete(); m_y.delete(); m_on.delete();
        x = 0; y = r; d = 1 - r;
        while (y >= x) begin
            px = '{cx+x, cx+y, cx-x, cx-y, cx-x, cx-y, cx+x, cx+y};
            py = '{cy+y, cy+x, cy+y, cy+x, cy-y, cy-x, cy-y, cy-x};
            for (int k = 0; k < 8; k++) begin
                m_x.push_back(px[k]);
                m_y.push_back(py[k]);
                m_on.push_back(px[k] >= 0 && px[k] < 160 && py[k] >= 0 && py[k] < 120);
            end
            x = x + 1;
            if (d <= 0) d = d + 2*x + 1;
            else begin
                y = y - 1;
                d = d + 2*(x - y) + 1;
            end
        end
    endfunction

    int cap_x[$];
    int cap_y[$];
    int done_edge;

    // Assumes start is high and the next rising edge is the one that sees it in IDLE.
    task automatic capture(input string tag, input int col, input int exp_cycles, input int drop_at);
        int n;
        n = m_x.size();
        cap_x.delete(); cap_y.delete();
        done_edge = -1;
        for (int e = 0; e < exp_cycles + 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == drop_at) start = 1'b0;
            if (e >= 2 && e - 2 < n) begin
                chk({tag, " plot"}, int'(vga_plot), int'(m_on[e-2]));
                if (m_on[e-2]) begin
                    chk({tag, " x"}, int'(vga_x), m_x[e-2]);
                    chk({tag, " y"}, int'(vga_y), m_y[e-2]);
                    chk({tag, " colour"}, int'(vga_colour), col);
                end
                if (vga_plot) begin
                    cap_x.push_back(int'(vga_x));
                    cap_y.push_back(int'(vga_y));
                end
            end else begin
                chk({tag, " idle plot"}, int'(vga_plot), 0);
            end
            if (done) begin
                done_edge = e;
                break;
            end
        end
        chk({tag, " done latency"}, done_edge, exp_cycles + 2);
    endtask

    typedef struct {
        int cx;
        int cy;
        int r;
        int col;
        int exp_cycles;
    } vec_t;

    vec_t vecs[5];

    int h_x[16];
    int h_y[16];

    initial begin
        vecs[0] = '{cx: 80,  cy: 60,  r: 0,  col: 5, exp_cycles: 8};
        vecs[1] = '{cx: 80,  cy: 60,  r: 1,  col: 2, exp_cycles: 16};
        vecs[2] = '{cx: 80,  cy: 60,  r: 40, col: 7, exp_cycles: 232};
        vecs[3] = '{cx: 0,   cy: 0,   r: 10, col: 1, exp_cycles: 64};
        vecs[4] = '{cx: 159, cy: 119, r: 30, col: 6, exp_cycles: 176};
        h_x = '{80, 81, 80, 79, 80, 79, 80, 81, 81, 81, 79, 79, 79, 79, 81, 81};
        h_y = '{61, 60, 61, 60, 59, 60, 59, 60, 61, 61, 61, 61, 59, 59, 59, 59};

        rst_n = 1'b0; start = 1'b0; colour = '0;
        centre_x = '0; centre_y = '0; radius = '0;
        #12;
        chk("reset plot", int'(vga_plot), 0);
        chk("reset done", int'(done), 0);
        chk("reset x", int'(vga_x), 0);
        chk("reset y", int'(vga_y), 0);
        chk("reset colour", int'(vga_colour), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            string tag;
            int plotted;
            tag = $sformatf("v%0d", i);
            centre_x = 8'(vecs[i].cx);
            centre_y = 7'(vecs[i].cy);
            radius   = 8'(vecs[i].r);
            colour   = 3'(vecs[i].col);
            build_model(vecs[i].cx, vecs[i].cy, vecs[i].r);
            start = 1'b1;
            capture(tag, vecs[i].col, vecs[i].exp_cycles, -1);

            plotted = 0;
            foreach (m_on[k]) if (m_on[k]) plotted++;
            chk({tag, " plot count"}, cap_x.size(), plotted);

            if (i == 0) begin
                chk("r0 plot count", cap_x.size(), 8);
                foreach (cap_x[k]) begin
                    chk("r0 px", cap_x[k], 80);
                    chk("r0 py", cap_y[k], 60);
                end
            end
            if (i == 1) begin
                chk("r1 plot count", cap_x.size(), 16);
                for (int k = 0; k < 16 && k < cap_x.size(); k++) begin
                    chk($sformatf("r1 px[%0d]", k), cap_x[k], h_x[k]);
                    chk($sformatf("r1 py[%0d]", k), cap_y[k], h_y[k]);
                end
            end
            if (i == 2) begin
                foreach (cap_x[k]) begin
                    int dx, dy, err;
                    dx = cap_x[k] - 80;
                    dy = cap_y[k] - 60;
                    err = dx*dx + dy*dy - 1600;
                    if (err < 0) err = -err;
                    chk("r40 on circle", int'(err <= 80), 1);
                end
            end
            if (i >= 3) begin
                foreach (cap_x[k]) begin
                    chk({tag, " x in range"}, int'(cap_x[k] <= 159), 1);
                    chk({tag, " y in range"}, int'(cap_y[k] <= 119), 1);
                    if (i == 3) begin
                        chk("clip x near origin", int'(cap_x[k] <= 10), 1);
                        chk("clip y near origin", int'(cap_y[k] <= 10), 1);
                    end
                end
            end

            // start still high: done holds and nothing retriggers.
            repeat (3) begin
                @(posedge clk); @(negedge clk);
                chk({tag, " done held"}, int'(done), 1);
                chk({tag, " no retrigger"}, int'(vga_plot), 0);
            end
            start = 1'b0;
            @(posedge clk); @(negedge clk);
            chk({tag, " done cleared"}, int'(done), 0);
            repeat (2) @(negedge clk);
        end

        // start dropped mid-draw: draw completes, done pulses for one cycle.
        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd1; colour = 3'd3;
        build_model(80, 60, 1);
        start = 1'b1;
        capture("drop", 3, 16, 3);
        chk("drop start low", int'(start), 0);
        @(posedge clk); @(negedge clk);
        chk("drop done pulse end", int'(done), 0);
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            chk("drop stays idle", int'(vga_plot), 0);
        end

        // Asynchronous reset during the third iteration, then a full redraw.
        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'd4;
        build_model(80, 60, 40);
        start = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        chk("pre-reset plotting", int'(vga_plot), 1);
        rst_n = 1'b0;
        #1;
        chk("async rst plot", int'(vga_plot), 0);
        chk("async rst done", int'(done), 0);
        chk("async rst x", int'(vga_x), 0);
        @(posedge clk); @(negedge clk);
        chk("in rst plot", int'(vga_plot), 0);
        rst_n = 1'b1;
        capture("redraw", 4, 232, -1);
        chk("redraw first x", (cap_x.size() > 0) ? cap_x[0] : -1, 80);
        chk("redraw first y", (cap_y.size() > 0) ? cap_y[0] : -1, 100);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("redraw done cleared", int'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
